// File: rtl/ad9914_update_sched.sv
// Round-robin update scheduler for the AD9914 channel controllers: one channel in flight at a time.
// Optional WAIT_DONE watchdog enabled by defining AD9914_SCHED_TIMEOUT_EN.
module ad9914_update_sched #(
    parameter int NUM_CH      = 4,
    parameter int FTW_W       = 32,
    parameter int BUSY_WAIT   = 16,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH*FTW_W-1:0] req_ftw_l,
    input  logic [NUM_CH*FTW_W-1:0] req_ftw_u,
    output logic [NUM_CH-1:0]       ch_update,
    output logic [NUM_CH*FTW_W-1:0] ch_lower_limit,
    output logic [NUM_CH*FTW_W-1:0] ch_upper_limit,
    input  logic [NUM_CH-1:0]       ch_busy,
    output logic                    done,
    output logic [2:0]              done_ch,
    output logic                    err,
    output logic                    idle,
    output logic [1:0]              dbg_state
);

    // Handshake: a request transfers on the clock edge where req_valid[k] and req_ready[k]
    // are both high; req_ready is combinational and only ever one-hot while the FSM is IDLE.

    localparam int BW_W = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    if (NUM_CH < 2 || NUM_CH > 8 || BUSY_WAIT < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("ad9914_update_sched: parameter out of range");
    end

    state_t                  state_q;
    logic [2:0]              sel_q;
    logic [2:0]              rr_q;
    logic [NUM_CH-1:0]       upd_q;
    logic                    done_q;
    logic                    err_q;
    logic [2:0]              done_ch_q;
    logic [BW_W-1:0]         bw_cnt_q;
    logic [NUM_CH*FTW_W-1:0] lower_q;
    logic [NUM_CH*FTW_W-1:0] upper_q;
`ifdef AD9914_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]         to_cnt_q;
`endif

    logic [7:0]        req_ext;
    logic [7:0]        busy_ext;
    logic              grant_found;
    logic [2:0]        grant_idx;
    logic [3:0]        cand;
    logic [NUM_CH-1:0] grant_oh;
    logic              busy_sel;
    logic [2:0]        rr_next;

    assign req_ext  = 8'(req_valid);
    assign busy_ext = 8'(ch_busy);
    assign busy_sel = busy_ext[sel_q];
    assign rr_next  = (sel_q == 3'(NUM_CH - 1)) ? 3'd0 : sel_q + 3'd1;

    // First requester at or after the round-robin pointer, wrapping at NUM_CH.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_q} + 4'(i);
            if (cand >= 4'(NUM_CH)) begin
                cand = cand - 4'(NUM_CH);
            end
            if (!grant_found && req_ext[cand[2:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    assign grant_oh  = NUM_CH'(8'd1 << grant_idx);
    assign req_ready = (state_q == S_IDLE && grant_found) ? grant_oh : '0;
    assign idle      = (state_q == S_IDLE) && !(|req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            rr_q      <= '0;
            upd_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            done_ch_q <= '0;
            bw_cnt_q  <= '0;
            lower_q   <= '0;
            upper_q   <= '0;
`ifdef AD9914_SCHED_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        sel_q <= grant_idx;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (grant_idx == 3'(i)) begin
                                lower_q[i*FTW_W +: FTW_W] <= req_ftw_l[i*FTW_W +: FTW_W];
                                upper_q[i*FTW_W +: FTW_W] <= req_ftw_u[i*FTW_W +: FTW_W];
                            end
                        end
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    upd_q    <= NUM_CH'(8'd1 << sel_q);
                    bw_cnt_q <= '0;
                    state_q  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (busy_sel) begin
                        upd_q   <= '0;
`ifdef AD9914_SCHED_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                        state_q <= S_WAIT_DONE;
                    end else if (bw_cnt_q == BW_W'(BUSY_WAIT - 1)) begin
                        // Controller never acknowledged: abandon the channel and move on.
                        upd_q     <= '0;
                        err_q     <= 1'b1;
                        done_ch_q <= sel_q;
                        rr_q      <= rr_next;
                        state_q   <= S_IDLE;
                    end else begin
                        bw_cnt_q <= bw_cnt_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy_sel) begin
                        done_q    <= 1'b1;
                        done_ch_q <= sel_q;
                        rr_q      <= rr_next;
                        state_q   <= S_IDLE;
                    end
`ifdef AD9914_SCHED_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        err_q     <= 1'b1;
                        done_ch_q <= sel_q;
                        rr_q      <= rr_next;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ch_update      = upd_q;
    assign ch_lower_limit = lower_q;
    assign ch_upper_limit = upper_q;
    assign done           = done_q;
    assign err            = err_q;
    assign done_ch        = done_ch_q;
    assign dbg_state      = state_q;

endmodule
